lifo_burst_reader: RTL and testbench

Downstream drain stage for the LIFO: pops words from the LIFO read port and presents them as length-bounded bursts on a valid/ready stream with a `last` marker. It absorbs the LIFO's one-cycle read latency with a credit-controlled output buffer, so it never overruns the buffer and never pops an empty LIFO. It is the sole reader of the LIFO.

---
 rtl/lifo_burst_reader.sv | 149 ++++++++++++++
 tb/tb_lifo_burst_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_burst_reader.sv
// Drains a LIFO into length-bounded valid/ready bursts with a last marker,
// absorbing the LIFO read latency in a small credit-controlled FIFO.
// Optional statistics counters are enabled by defining LIFO_BURST_READER_STATS_EN.
module lifo_burst_reader #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 8,
  parameter int BURST     = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srst,
  output logic              lifo_rdreq,
  input  logic [DWIDTH-1:0] lifo_q,
  input  logic              lifo_empty,
  input  logic [AWIDTH:0]   lifo_usedw,
  input  logic              flush,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef LIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]       pop_cnt,
  output logic [15:0]       burst_cnt
`endif
);

  localparam int CW = $clog2(BURST + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int UW = AWIDTH + 1;

  localparam logic [UW-1:0] C_BURST_U = UW'(BURST);
  localparam logic [CW-1:0] C_BURST_C = CW'(BURST);
  localparam logic [OW:0]   C_DEPTH   = (OW + 1)'(BUF_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_len;
  logic [CW-1:0]     r_issued;
  logic              r_flush_pend;
  logic              r_inflight;
  logic              r_tag;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [OW-1:0]     r_occ;
  logic [DWIDTH:0]   r_mem [BUF_DEPTH];

  logic              w_start_full;
  logic              w_start_flush;
  logic              w_pend_clr;
  logic              w_credit_ok;
  logic              w_rdreq;
  logic              w_issue_last;
  logic              w_pop;
  logic [DWIDTH:0]   w_head;

  assign w_start_full  = (r_state == S_IDLE) && (lifo_usedw >= C_BURST_U);
  assign w_start_flush = (r_state == S_IDLE) && !w_start_full && r_flush_pend && !lifo_empty;
  assign w_pend_clr    = (r_state == S_IDLE) && (lifo_empty || w_start_flush);

  // Words already requested count against buffer space until they land.
  assign w_credit_ok  = ({1'b0, r_occ} + {{OW{1'b0}}, r_inflight}) < C_DEPTH;
  assign w_rdreq      = !srst && (r_state == S_BURST) && w_credit_ok && (r_issued < r_len);
  assign w_issue_last = w_rdreq && ((r_issued + CW'(1)) == r_len);
  assign w_pop        = (r_occ != '0) && out_ready;

  assign w_head     = r_mem[r_rptr];
  assign lifo_rdreq = w_rdreq;
  assign out_valid  = (r_occ != '0);
  assign out_data   = out_valid ? w_head[DWIDTH-1:0] : '0;
  assign out_last   = out_valid && w_head[DWIDTH];
  assign busy       = (r_state == S_BURST);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_issued     <= '0;
      r_flush_pend <= 1'b0;
      r_inflight   <= 1'b0;
      r_tag        <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
    end else begin
      r_flush_pend <= flush | (r_flush_pend & ~w_pend_clr);
      r_inflight   <= w_rdreq;
      r_tag        <= w_issue_last;

      if (r_state == S_IDLE) begin
        if (w_start_full) begin
          r_state  <= S_BURST;
          r_len    <= C_BURST_C;
          r_issued <= '0;
        end else if (w_start_flush) begin
          // usedw is below BURST here, so the narrow slice is lossless.
          r_state  <= S_BURST;
          r_len    <= lifo_usedw[CW-1:0];
          r_issued <= '0;
        end
      end else begin
        if (w_rdreq) begin
          r_issued <= r_issued + CW'(1);
        end
        if (w_issue_last) begin
          r_state <= S_IDLE;
        end
      end

      if (r_inflight) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({r_inflight, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_mem[r_wptr] <= {r_tag, lifo_q};
    end
  end

`ifdef LIFO_BURST_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      pop_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      if (w_rdreq) begin
        pop_cnt <= pop_cnt + 32'd1;
      end
      if (w_start_full || w_start_flush) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lifo_burst_reader.sv
// Bench for lifo_burst_reader: behavioural LIFO, stream collector and a
// rule-level burst model for expected output order and last markers.
module tb_lifo_burst_reader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BL = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          lifo_rdreq;
  logic [DW-1:0] lifo_q = '0;
  logic          lifo_empty = 1'b1;
  logic [AW:0]   lifo_usedw = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
`ifdef LIFO_BURST_READER_STATS_EN
  logic [31:0]   pop_cnt;
  logic [15:0]   burst_cnt;
`endif

  always #5 clk = ~clk;

  lifo_burst_reader #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .BURST(BL),
    .BUF_DEPTH(BD)
  ) dut (
    .clk(clk),
    .srst(srst),
    .lifo_rdreq(lifo_rdreq),
    .lifo_q(lifo_q),
    .lifo_empty(lifo_empty),
    .lifo_usedw(lifo_usedw),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy)
`ifdef LIFO_BURST_READER_STATS_EN
    ,
    .pop_cnt(pop_cnt),
    .burst_cnt(burst_cnt)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LIFO: one-cycle read latency, registered fill level.
  logic [DW-1:0] mem[$];
  int pops = 0;
  int underflow = 0;
  int pop_cyc[$];
  always @(posedge clk) begin
    if (lifo_rdreq) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (mem.size() == 0) underflow++;
      else lifo_q <= mem.pop_back();
    end
    lifo_usedw <= (AW + 1)'(mem.size());
    lifo_empty <= (mem.size() == 0);
  end

  logic [DW:0] got[$];
  int got_cyc[$];
  int busy_cyc = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got.push_back({out_last, out_data});
      got_cyc.push_back(cyc);
    end
    if (busy) busy_cyc++;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst  = 1'b1;
    flush = 1'b0;
    repeat (2) tick();
    srst = 1'b0;
  endtask

  task automatic clr();
    got.delete();
    got_cyc.delete();
    pop_cyc.delete();
    busy_cyc = 0;
  endtask

  task automatic fill(input logic [DW-1:0] p[$]);
    foreach (p[i]) mem.push_back(p[i]);
  endtask

  task automatic rand_words(input int n, output logic [DW-1:0] p[$]);
    p = {};
    for (int i = 0; i < n; i++) p.push_back(DW'($urandom));
  endtask

  // Runs until the reader has been idle with an empty stream for 4 cycles.
  task automatic wait_quiet(input string tag, input int flush_at, input bit rnd);
    int  q;
    bit  done;
    q    = 0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      flush     = (i == flush_at);
      out_ready = rnd ? 1'($urandom) : 1'b1;
      @(negedge clk);
      if (!busy && !out_valid && !lifo_rdreq && i > flush_at) q++;
      else q = 0;
      if (q >= 4) done = 1'b1;
    end
    flush = 1'b0;
    check({tag, "_drain_done"}, 32'(done), 32'd1);
  endtask

  // Stack popped top-first; full bursts of BL while enough words remain,
  // the remainder only as a flushed burst.
  logic [DW:0] expq[$];
  task automatic build_exp(input logic [DW-1:0] p[$], input bit fl);
    int rem;
    int idx;
    int len;
    rem = p.size();
    idx = p.size() - 1;
    expq = {};
    while (rem > 0) begin
      if (rem >= BL) len = BL;
      else if (fl) len = rem;
      else break;
      for (int k = 1; k <= len; k++) begin
        expq.push_back({(k == len), p[idx]});
        idx--;
      end
      rem -= len;
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, 32'(got.size()), 32'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(expq[i]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] p[$];
    logic [DW-1:0] p2[$];
    int base;
    int span;
    int lasts;
    bit seen;

    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rdreq", 32'(lifo_rdreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Full burst of 1..8, stream open.
    tick();
    clr();
    out_ready = 1'b1;
    p = {};
    for (int i = 1; i <= 8; i++) p.push_back(DW'(i));
    fill(p);
    wait_quiet("t1", -1, 1'b0);
    build_exp(p, 1'b0);
    compare_stream("t1");
    check("t1_pops", 32'(pop_cyc.size()), 32'd8);
    span = (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1;
    check("t1_pop_span", 32'(span), 32'd7);
    span = (got_cyc.size() == 8) ? got_cyc[7] - got_cyc[0] : -1;
    check("t1_out_span", 32'(span), 32'd7);
    check("t1_busy_cycles", 32'(busy_cyc), 32'd8);

    // Short fill waits for flush; flush pending is consumed by the burst.
    clr();
    base = pops;
    rand_words(3, p);
    fill(p);
    repeat (20) tick();
    check("t2_no_pop", 32'(pops - base), 32'd0);
    wait_quiet("t2", 0, 1'b0);
    build_exp(p, 1'b1);
    compare_stream("t2");
    clr();
    base = pops;
    rand_words(3, p2);
    fill(p2);
    repeat (20) tick();
    check("t2_pend_cleared", 32'(pops - base), 32'd0);
    wait_quiet("t2b", 0, 1'b0);
    build_exp(p2, 1'b1);
    compare_stream("t2b");

    // Back-pressure: only BD words popped while the stream is stalled.
    clr();
    base = pops;
    out_ready = 1'b0;
    rand_words(16, p);
    fill(p);
    repeat (15) tick();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check($sformatf("t3_pops_%0d", r), 32'(pops - base), 32'(BD));
      check($sformatf("t3_rdreq_%0d", r), 32'(lifo_rdreq), 32'd0);
      check($sformatf("t3_valid_%0d", r), 32'(out_valid), 32'd1);
      check($sformatf("t3_data_%0d", r), 32'(out_data), 32'(p[15]));
      check($sformatf("t3_last_%0d", r), 32'(out_last), 32'd0);
      tick();
    end
    wait_quiet("t3", -1, 1'b0);
    build_exp(p, 1'b0);
    compare_stream("t3");
    lasts = 0;
    foreach (got[i]) if (got[i][DW]) lasts++;
    check("t3_last_count", 32'(lasts), 32'd2);

    // Reset in the cycle following a pop drops the returning word.
    clr();
    out_ready = 1'b1;
    rand_words(8, p);
    fill(p);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lifo_rdreq) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_pop_seen", 32'(seen), 32'd1);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_rdreq", 32'(lifo_rdreq), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    check("t4_no_output", 32'(got.size()), 32'd0);
    mem.delete();
    repeat (3) tick();

    // Flush with an empty LIFO must not linger.
    clr();
    base = pops;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    check("t5_no_pop_empty", 32'(pops - base), 32'd0);
    rand_words(3, p);
    fill(p);
    repeat (20) tick();
    check("t5_pend_cleared", 32'(pops - base), 32'd0);
    mem.delete();
    repeat (3) tick();

    // Randomised fills with random back-pressure and flush timing.
    for (int r = 0; r < 6; r++) begin
      clr();
      rand_words($urandom_range(1, 24), p);
      fill(p);
      wait_quiet($sformatf("r%0d", r), $urandom_range(0, 12), 1'b1);
      build_exp(p, 1'b1);
      compare_stream($sformatf("r%0d", r));
    end

`ifdef LIFO_BURST_READER_STATS_EN
    tick();
    do_reset();
    @(negedge clk);
    check("st_pop_rst", pop_cnt, 32'd0);
    check("st_burst_rst", 32'(burst_cnt), 32'd0);
    tick();
    clr();
    rand_words(16, p);
    fill(p);
    wait_quiet("st", -1, 1'b0);
    check("st_pop_cnt", pop_cnt, 32'd16);
    check("st_burst_cnt", 32'(burst_cnt), 32'd2);
`endif

    check("lifo_underflow", 32'(underflow), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
